// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the PC, issues word-addressed fetch
// requests over valid/ready, and queues branch redirects across stalls.
module pc_sequencer #(
    parameter int              WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] pc_branch,
    input  logic             halt,
    input  logic             resume,
    input  logic             fetch_ready,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus1,
    output logic             redirect_pending,
    output logic [WIDTH-1:0] fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             xfer;
    logic [WIDTH-1:0] target;

    assign pc_plus1 = pc + WIDTH'(1);
    assign xfer     = fetch_valid & fetch_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (xfer && halt) state_nxt = HALT;
            HALT:    if (resume) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    always_comb begin
        fetch_valid = (state == RUN);
    end

    // The stalled request keeps its PC; a redirect seen during the stall
    // is parked in target and applied on the transfer that ends it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc               <= RESET_PC;
            target           <= '0;
            redirect_pending <= 1'b0;
            fetch_count      <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (xfer) begin
                        fetch_count      <= fetch_count + WIDTH'(1);
                        redirect_pending <= 1'b0;
                        if (branch_taken) begin
                            pc <= pc_branch;
                        end else if (redirect_pending) begin
                            pc <= target;
                        end else begin
                            pc <= pc_plus1;
                        end
                    end else if (branch_taken) begin
                        target           <= pc_branch;
                        redirect_pending <= 1'b1;
                    end
                end
                HALT: begin
                    if (branch_taken) begin
                        pc               <= pc_branch;
                        redirect_pending <= 1'b0;
                    end else if (redirect_pending) begin
                        pc               <= target;
                        redirect_pending <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, stall, redirects, halt/resume,
// 8-bit wrap and asynchronous reset.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        branch_taken;
    logic [31:0] pc_branch;
    logic        halt;
    logic        resume;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic        redirect_pending;
    logic [31:0] fetch_count;

    logic        w_valid;
    logic [7:0]  w_pc;
    logic [7:0]  w_plus1;
    logic        w_pending;
    logic [7:0]  w_count;

    int vectors;
    int miscompares;

    pc_sequencer #(.WIDTH(32), .RESET_PC(32'h100)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .branch_taken     (branch_taken),
        .pc_branch        (pc_branch),
        .halt             (halt),
        .resume           (resume),
        .fetch_ready      (fetch_ready),
        .fetch_valid      (fetch_valid),
        .pc               (pc),
        .pc_plus1         (pc_plus1),
        .redirect_pending (redirect_pending),
        .fetch_count      (fetch_count)
    );

    pc_sequencer #(.WIDTH(8), .RESET_PC(8'hFE)) dut_w (
        .clk              (clk),
        .rst_n            (rst_n),
        .branch_taken     (1'b0),
        .pc_branch        (8'h00),
        .halt             (1'b0),
        .resume           (1'b0),
        .fetch_ready      (1'b1),
        .fetch_valid      (w_valid),
        .pc               (w_pc),
        .pc_plus1         (w_plus1),
        .redirect_pending (w_pending),
        .fetch_count      (w_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic v,
                            input logic [31:0] p, input logic pend,
                            input logic [31:0] cnt);
        chk({tag, ".valid"}, {31'd0, fetch_valid}, {31'd0, v});
        chk({tag, ".pc"}, pc, p);
        chk({tag, ".pending"}, {31'd0, redirect_pending}, {31'd0, pend});
        chk({tag, ".count"}, fetch_count, cnt);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b1;
        branch_taken = 1'b0;
        pc_branch    = '0;
        halt         = 1'b0;
        resume       = 1'b0;
        fetch_ready  = 1'b1;

        #2 rst_n = 1'b0;
        #5;
        chk_main("reset", 1'b0, 32'h100, 1'b0, 32'd0);
        chk("reset.plus1", pc_plus1, 32'h101);

        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("boot.valid", {31'd0, fetch_valid}, 32'd0);
        tick();
        chk_main("run0", 1'b1, 32'h100, 1'b0, 32'd0);
        tick();
        chk_main("run1", 1'b1, 32'h101, 1'b0, 32'd1);
        tick();
        chk_main("run2", 1'b1, 32'h102, 1'b0, 32'd2);
        tick();
        chk_main("run3", 1'b1, 32'h103, 1'b0, 32'd3);
        tick();
        chk_main("run4", 1'b1, 32'h104, 1'b0, 32'd4);

        fetch_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_main("stall", 1'b1, 32'h104, 1'b0, 32'd4);
        end
        fetch_ready = 1'b1;
        tick();
        chk_main("unstall", 1'b1, 32'h105, 1'b0, 32'd5);

        branch_taken = 1'b1;
        pc_branch    = 32'h08;
        tick();
        chk_main("br08", 1'b1, 32'h08, 1'b0, 32'd6);
        pc_branch = 32'h20;
        tick();
        chk_main("same_cycle", 1'b1, 32'h20, 1'b0, 32'd7);
        pc_branch = 32'h10;
        tick();
        chk_main("br10", 1'b1, 32'h10, 1'b0, 32'd8);

        fetch_ready = 1'b0;
        pc_branch   = 32'h40;
        tick();
        chk_main("pend1", 1'b1, 32'h10, 1'b1, 32'd8);
        branch_taken = 1'b0;
        tick();
        chk_main("pend2", 1'b1, 32'h10, 1'b1, 32'd8);
        branch_taken = 1'b1;
        pc_branch    = 32'h80;
        tick();
        chk_main("pend3", 1'b1, 32'h10, 1'b1, 32'd8);
        branch_taken = 1'b0;
        fetch_ready  = 1'b1;
        tick();
        chk_main("pend_xfer", 1'b1, 32'h80, 1'b0, 32'd9);

        branch_taken = 1'b1;
        pc_branch    = 32'h30;
        tick();
        chk_main("br30", 1'b1, 32'h30, 1'b0, 32'd10);
        branch_taken = 1'b0;
        halt         = 1'b1;
        fetch_ready  = 1'b0;
        tick();
        chk_main("halt_stall1", 1'b1, 32'h30, 1'b0, 32'd10);
        tick();
        chk_main("halt_stall2", 1'b1, 32'h30, 1'b0, 32'd10);
        fetch_ready = 1'b1;
        tick();
        chk_main("halted", 1'b0, 32'h31, 1'b0, 32'd11);
        halt = 1'b0;
        tick();
        chk_main("halt_hold", 1'b0, 32'h31, 1'b0, 32'd11);
        branch_taken = 1'b1;
        pc_branch    = 32'h50;
        tick();
        chk_main("halt_br", 1'b0, 32'h50, 1'b0, 32'd11);
        branch_taken = 1'b0;
        resume       = 1'b1;
        halt         = 1'b1;
        tick();
        chk_main("resume", 1'b1, 32'h50, 1'b0, 32'd11);
        resume = 1'b0;
        halt   = 1'b0;
        tick();
        chk_main("resume_run", 1'b1, 32'h51, 1'b0, 32'd12);

        fetch_ready  = 1'b0;
        branch_taken = 1'b1;
        pc_branch    = 32'h77;
        tick();
        chk_main("pre_rst", 1'b1, 32'h51, 1'b1, 32'd12);
        branch_taken = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk_main("async_rst", 1'b0, 32'h100, 1'b0, 32'd0);
        chk("w.rst_pc", {24'd0, w_pc}, 32'hFE);
        chk("w.rst_pend", {31'd0, w_pending}, 32'd0);

        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        chk("w.pc0", {24'd0, w_pc}, 32'hFE);
        chk("w.valid", {31'd0, w_valid}, 32'd1);
        tick();
        chk("w.pcFF", {24'd0, w_pc}, 32'hFF);
        chk("w.plus1", {24'd0, w_plus1}, 32'h00);
        tick();
        chk("w.wrap", {24'd0, w_pc}, 32'h00);
        chk("w.count", {24'd0, w_count}, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
